// File: rtl/bcd_serial_adder_ctrl_if.sv
// Request/response bundle for the serial BCD adder sequencer.
// The master issues operands and start; the slave returns status and the packed sum.
interface bcd_serial_adder_ctrl_if #(
   parameter int unsigned DIGITS = 4
);
   logic                  start;
   logic [4*DIGITS-1:0]   op_a;
   logic [4*DIGITS-1:0]   op_b;
   logic                  cin;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   result;
   logic                  cout_final;
   logic                  err;

   modport master (
      output start, op_a, op_b, cin,
      input  busy, done, result, cout_final, err
   );

   modport slave (
      input  start, op_a, op_b, cin,
      output busy, done, result, cout_final, err
   );
endinterface

// File: rtl/bcd_serial_adder_ctrl.sv
// Multi-digit BCD addition sequencer: streams one digit pair per cycle through an
// external single-digit bcd_adder, rippling the carry through a register.
module bcd_serial_adder_ctrl #(
   parameter int unsigned DIGITS = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   bcd_serial_adder_ctrl_if.slave   bus,
   output logic [3:0]               add_a,
   output logic [3:0]               add_b,
   output logic                     add_cin,
   input  logic [3:0]               add_sum,
   input  logic                     add_cout
);
   localparam int unsigned W    = 4 * DIGITS;
   localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

   state_e            state_q, state_d;
   logic [W-1:0]      a_q, a_d;
   logic [W-1:0]      b_q, b_d;
   logic [W-1:0]      result_q, result_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic              carry_q, carry_d;
   logic              cout_q, cout_d;
   logic              err_q, err_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      logic bad;
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      err_d    = err_q;
      add_a    = 4'h0;
      add_b    = 4'h0;
      add_cin  = 1'b0;
      bad      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               for (int i = 0; i < int'(DIGITS); i++) begin
                  if (bus.op_a[4*i +: 4] > 4'd9 || bus.op_b[4*i +: 4] > 4'd9) bad = 1'b1;
               end
               state_d  = StAdd;
               a_d      = bus.op_a;
               b_d      = bus.op_b;
               carry_d  = bus.cin;
               idx_d    = '0;
               result_d = '0;
               cout_d   = 1'b0;
               err_d    = bad;
            end
         end
         StAdd: begin
            // Operands shift right so the current digit is always in bits [3:0].
            add_a   = a_q[3:0];
            add_b   = b_q[3:0];
            add_cin = carry_q;
            result_d[{idx_q, 2'b00} +: 4] = add_sum;
            carry_d = add_cout;
            a_d     = a_q >> 4;
            b_d     = b_q >> 4;
            if (idx_q == IdxW'(DIGITS - 1)) begin
               state_d = StDone;
               cout_d  = add_cout;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign bus.busy       = (state_q != StIdle);
   assign bus.done       = (state_q == StDone);
   assign bus.result     = result_q;
   assign bus.cout_final = cout_q;
   assign bus.err        = err_q;
endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Randomised and directed bench for bcd_serial_adder_ctrl with a behavioural
// single-digit BCD adder on the add_* ports and a decimal reference model.
module tb_bcd_serial_adder_ctrl;
   localparam int unsigned D = 4;
   localparam int unsigned W = 4 * D;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] add_a, add_b, add_sum;
   logic       add_cin, add_cout;
   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   bcd_serial_adder_ctrl_if #(.DIGITS(D)) bus ();

   bcd_serial_adder_ctrl #(.DIGITS(D)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_sum  (add_sum),
      .add_cout (add_cout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Single-digit BCD adder stage: binary sum with +6 correction above 9.
   always_comb begin
      logic [4:0] s;
      s = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
      if (s > 5'd9) begin
         add_sum  = 4'(s[3:0] + 4'd6);
         add_cout = 1'b1;
      end else begin
         add_sum  = s[3:0];
         add_cout = 1'b0;
      end
   end

   function automatic logic ref_err(input logic [W-1:0] a, input logic [W-1:0] b);
      logic e;
      e = 1'b0;
      for (int i = 0; i < int'(D); i++) if (a[4*i +: 4] > 9 || b[4*i +: 4] > 9) e = 1'b1;
      return e;
   endfunction

   // Returns {cout_final, result}. Valid operands use plain decimal arithmetic.
   function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic c);
      logic [W:0] r;
      r = '0;
      if (!ref_err(a, b)) begin
         longint unsigned va, vb, p, tot, m;
         va = 0; vb = 0; p = 1;
         for (int i = 0; i < int'(D); i++) begin
            va += longint'(a[4*i +: 4]) * p;
            vb += longint'(b[4*i +: 4]) * p;
            p  *= 10;
         end
         tot  = va + vb + longint'(c);
         r[W] = (tot >= p);
         m    = tot % p;
         for (int i = 0; i < int'(D); i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
         end
      end else begin
         logic cy;
         int s;
         cy = c;
         for (int i = 0; i < int'(D); i++) begin
            s = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + int'(cy);
            if (s > 9) begin
               r[4*i +: 4] = 4'(s + 6);
               cy = 1'b1;
            end else begin
               r[4*i +: 4] = 4'(s);
               cy = 1'b0;
            end
         end
         r[W] = cy;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] rand_bcd();
      logic [W-1:0] v;
      for (int i = 0; i < int'(D); i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
      return v;
   endfunction

   // Issues one operation from IDLE and waits (bounded) for done; lat counts cycles
   // from the accept edge to the done cycle, -1 on timeout.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         output logic [W-1:0] res, output logic co, output logic er,
                         output int lat, output int t_done);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op_a  = a;
      bus.op_b  = b;
      bus.cin   = c;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      bus.op_a  = W'($urandom);
      bus.op_b  = W'($urandom);
      bus.cin   = 1'($urandom);
      lat = 1;
      while (!bus.done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!bus.done) lat = -1;
      res    = bus.result;
      co     = bus.cout_final;
      er     = bus.err;
      t_done = cyc;
   endtask

   task automatic test_reset();
      bus.start = 1'b0;
      bus.op_a  = '0;
      bus.op_b  = '0;
      bus.cin   = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if ({bus.busy, bus.done, bus.cout_final, bus.err} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_flags: got busy/done/cout/err=%b want 0000",
                  {bus.busy, bus.done, bus.cout_final, bus.err});
      end
      n_cmp++;
      if (bus.result !== 16'h0000) begin
         n_bad++;
         $display("FAIL reset_result: got %h want 0000", bus.result);
      end
      n_cmp++;
      if ({add_a, add_b, add_cin} !== 9'd0) begin
         n_bad++;
         $display("FAIL reset_adder_drive: got a=%h b=%h cin=%b want 0", add_a, add_b, add_cin);
      end
   endtask

   task automatic test_basic();
      logic [W-1:0] res; logic co, er; int lat, t;
      run_op(16'h1234, 16'h5678, 1'b0, res, co, er, lat, t);
      n_cmp++;
      if (lat !== 5) begin
         n_bad++;
         $display("FAIL basic_latency: got %0d want 5", lat);
      end
      n_cmp++;
      if ({co, er, res} !== {1'b0, 1'b0, 16'h6912}) begin
         n_bad++;
         $display("FAIL basic_sum: got cout=%b err=%b res=%h want 0 0 6912", co, er, res);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
         n_bad++;
         $display("FAIL done_pulse_width: got done=%b busy=%b want 0 0", bus.done, bus.busy);
      end
   endtask

   task automatic test_carry();
      logic [W-1:0] res; logic co, er; int lat, t;
      run_op(16'h9999, 16'h0001, 1'b0, res, co, er, lat, t);
      n_cmp++;
      if ({co, res} !== {1'b1, 16'h0000}) begin
         n_bad++;
         $display("FAIL wrap_overflow: got cout=%b res=%h want 1 0000", co, res);
      end
      run_op(16'h0999, 16'h0000, 1'b1, res, co, er, lat, t);
      n_cmp++;
      if ({co, res} !== {1'b0, 16'h1000}) begin
         n_bad++;
         $display("FAIL cin_ripple: got cout=%b res=%h want 0 1000", co, res);
      end
   endtask

   task automatic test_hold_start();
      int pulses;
      logic [W-1:0] res1;
      bit   seen;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op_a  = 16'h1234;
      bus.op_b  = 16'h1111;
      bus.cin   = 1'b0;
      @(posedge clk);
      pulses = 0;
      res1   = '0;
      for (int k = 0; k <= int'(D); k++) begin
         @(negedge clk);
         if (k == 1) bus.op_a = 16'h4321;
         if (bus.done) begin
            pulses++;
            res1 = bus.result;
         end
      end
      n_cmp++;
      if (pulses !== 1) begin
         n_bad++;
         $display("FAIL hold_start_pulses: got %0d want 1", pulses);
      end
      n_cmp++;
      if (res1 !== 16'h2345) begin
         n_bad++;
         $display("FAIL hold_start_sum: got %h want 2345", res1);
      end
      @(negedge clk);
      bus.op_b = 16'h0000;
      n_cmp++;
      if (bus.busy !== 1'b0) begin
         n_bad++;
         $display("FAIL hold_start_idle: got busy=%b want 0", bus.busy);
      end
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (bus.done) seen = 1'b1;
         else @(negedge clk);
      end
      n_cmp++;
      if (!seen || bus.result !== 16'h4321) begin
         n_bad++;
         $display("FAIL hold_start_second: got done=%b res=%h want 1 4321", seen, bus.result);
      end
   endtask

   task automatic test_reset_abort();
      int pulses;
      logic [W-1:0] res; logic co, er; int lat, t;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op_a  = 16'h00F0;
      bus.op_b  = 16'h0001;
      bus.cin   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if ({bus.busy, bus.done, bus.cout_final, bus.err, bus.result} !== {4'b0000, 16'h0000}) begin
         n_bad++;
         $display("FAIL abort_outputs: got busy=%b done=%b cout=%b err=%b res=%h want all 0",
                  bus.busy, bus.done, bus.cout_final, bus.err, bus.result);
      end
      pulses = 0;
      for (int k = 0; k < int'(D) + 2; k++) begin
         @(negedge clk);
         if (bus.done || bus.busy) pulses++;
      end
      n_cmp++;
      if (pulses !== 0) begin
         n_bad++;
         $display("FAIL abort_no_done: got %0d active cycles want 0", pulses);
      end
      run_op(16'h0005, 16'h0004, 1'b0, res, co, er, lat, t);
      n_cmp++;
      if ({lat, co, er, res} !== {32'd5, 1'b0, 1'b0, 16'h0009}) begin
         n_bad++;
         $display("FAIL abort_recover: got lat=%0d cout=%b err=%b res=%h want 5 0 0 0009",
                  lat, co, er, res);
      end
   endtask

   task automatic test_err();
      logic [W-1:0] res; logic co, er; int lat, t;
      run_op(16'h00A0, 16'h0001, 1'b0, res, co, er, lat, t);
      n_cmp++;
      if ({er, co, res} !== {1'b1, 1'b0, 16'h0101}) begin
         n_bad++;
         $display("FAIL err_flag: got err=%b cout=%b res=%h want 1 0 0101", er, co, res);
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus.err !== 1'b1 || bus.result !== 16'h0101) begin
         n_bad++;
         $display("FAIL err_held: got err=%b res=%h want 1 0101", bus.err, bus.result);
      end
      run_op(16'h0042, 16'h0013, 1'b0, res, co, er, lat, t);
      n_cmp++;
      if ({er, res} !== {1'b0, 16'h0055}) begin
         n_bad++;
         $display("FAIL err_clear: got err=%b res=%h want 0 0055", er, res);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, res; logic c, co, er; logic [W:0] exp; int lat, t;
      for (int n = 0; n < 24; n++) begin
         if (n % 4 == 3) begin
            a = W'($urandom);
            b = W'($urandom);
         end else begin
            a = rand_bcd();
            b = rand_bcd();
         end
         c = 1'($urandom);
         exp = ref_sum(a, b, c);
         run_op(a, b, c, res, co, er, lat, t);
         n_cmp++;
         if ({lat, co, res, er} !== {32'd5, exp, ref_err(a, b)}) begin
            n_bad++;
            $display("FAIL random_op%0d: %h+%h+%b got lat=%0d cout=%b res=%h err=%b want 5 %b %h %b",
                     n, a, b, c, lat, co, res, er, exp[W], exp[W-1:0], ref_err(a, b));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a, b, res; logic co, er; logic [W:0] exp; int lat, t, t_prev;
      t_prev = -1;
      for (int n = 0; n < 6; n++) begin
         a = rand_bcd();
         b = rand_bcd();
         exp = ref_sum(a, b, 1'b0);
         run_op(a, b, 1'b0, res, co, er, lat, t);
         n_cmp++;
         if ({co, res} !== exp) begin
            n_bad++;
            $display("FAIL b2b_sum%0d: got %b %h want %b %h", n, co, res, exp[W], exp[W-1:0]);
         end
         if (t_prev >= 0) begin
            n_cmp++;
            if (t - t_prev !== int'(D) + 2) begin
               n_bad++;
               $display("FAIL b2b_interval%0d: got %0d want %0d", n, t - t_prev, D + 2);
            end
         end
         t_prev = t;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_carry();
      test_hold_start();
      test_reset_abort();
      test_err();
      test_random();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
